// File: rtl/timer_counter.sv
// 8-bit up/down timer counter with a clk-derived prescaled tick (/2, /4, /8, /16),
// single-cycle wrap pulses and sticky overflow/underflow status flags.
module timer_counter #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] count_start_value,
  input  logic                  count_load,
  input  logic                  count_enable,
  input  logic                  count_up_down,
  input  logic [1:0]            cks,
  input  logic                  ovf_clr,
  input  logic                  udf_clr,
  output logic [DATA_WIDTH-1:0] TCNT,
  output logic                  TMR_OVF,
  output logic                  TMR_UDF,
  output logic                  ovf_pulse,
  output logic                  udf_pulse
);

  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] w_mask;
  logic                   w_tick;
  logic                   w_wrap_ovf;
  logic                   w_wrap_udf;
  logic [DATA_WIDTH-1:0]  w_tcnt_nxt;

  // Modulo-2^DATA_WIDTH step; wrap-around falls out of the natural truncation.
  function automatic logic [DATA_WIDTH-1:0] f_step(input logic [DATA_WIDTH-1:0] v,
                                                   input logic up);
    return up ? (v + DATA_WIDTH'(1)) : (v - DATA_WIDTH'(1));
  endfunction

  // cks selects how many low prescaler bits must all be ones: cks=n checks presc[n:0].
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PRESC_WIDTH; i++) begin
      if (i <= int'(cks)) w_mask[i] = 1'b1;
    end
  end

  assign w_tick     = count_enable & ~count_load & ((r_presc & w_mask) == w_mask);
  assign w_wrap_ovf = w_tick &  count_up_down & (TCNT == '1);
  assign w_wrap_udf = w_tick & ~count_up_down & (TCNT == '0);
  assign w_tcnt_nxt = f_step(TCNT, count_up_down);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (count_load || !count_enable) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TCNT      <= '0;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= w_wrap_ovf;
      udf_pulse <= w_wrap_udf;
      if (count_load) begin
        TCNT <= count_start_value;
      end else if (w_tick) begin
        TCNT <= w_tcnt_nxt;
      end
    end
  end

  // A wrap on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TMR_OVF <= 1'b0;
      TMR_UDF <= 1'b0;
    end else begin
      TMR_OVF <= w_wrap_ovf | (TMR_OVF & ~ovf_clr);
      TMR_UDF <= w_wrap_udf | (TMR_UDF & ~udf_clr);
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: per-cycle vector table plus hand-written
// sequences for divide sweeps, set/clear collision, load hold and async reset.
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_start_value;
  logic       count_load, count_enable, count_up_down;
  logic [1:0] cks;
  logic       ovf_clr, udf_clr;
  logic [7:0] TCNT;
  logic       TMR_OVF, TMR_UDF, ovf_pulse, udf_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  timer_counter #(.DATA_WIDTH(8), .PRESC_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .count_start_value(count_start_value), .count_load(count_load),
    .count_enable(count_enable), .count_up_down(count_up_down), .cks(cks),
    .ovf_clr(ovf_clr), .udf_clr(udf_clr),
    .TCNT(TCNT), .TMR_OVF(TMR_OVF), .TMR_UDF(TMR_UDF),
    .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld, en, ud;
    logic [1:0] ck;
    logic [7:0] sv;
    logic       oc, uc;
    logic [7:0] e_tcnt;
    logic [3:0] e_flg; // {TMR_OVF, TMR_UDF, ovf_pulse, udf_pulse}
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic ld, en, ud, input logic [1:0] ck,
                              input logic [7:0] sv, input logic oc, uc,
                              input logic [7:0] e_tcnt, input logic [3:0] e_flg);
    vec_t v;
    v.ld = ld; v.en = en; v.ud = ud; v.ck = ck; v.sv = sv; v.oc = oc; v.uc = uc;
    v.e_tcnt = e_tcnt; v.e_flg = e_flg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, en, ud, input logic [1:0] ck,
                       input logic [7:0] sv, input logic oc, uc);
    count_load = ld; count_enable = en; count_up_down = ud; cks = ck;
    count_start_value = sv; ovf_clr = oc; udf_clr = uc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flg();
    return {TMR_OVF, TMR_UDF, ovf_pulse, udf_pulse};
  endfunction

  initial begin
    //               ld en ud ck  sv    oc uc  tcnt   flags
    vecs[0]  = mk(1, 0, 1, 0, 8'hFD, 0, 0, 8'hFD, 4'b0000);
    vecs[1]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'hFD, 4'b0000);
    vecs[2]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'hFE, 4'b0000);
    vecs[3]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'hFE, 4'b0000);
    vecs[4]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'hFF, 4'b0000);
    vecs[5]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'hFF, 4'b0000);
    vecs[6]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 4'b1010);
    vecs[7]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 4'b1000);
    vecs[8]  = mk(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 4'b1000);
    vecs[9]  = mk(0, 0, 1, 0, 8'h00, 1, 0, 8'h00, 4'b0000);
    vecs[10] = mk(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 4'b0000);
    vecs[11] = mk(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 4'b0000);
    vecs[12] = mk(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 4'b0000);
    vecs[13] = mk(0, 1, 0, 1, 8'h00, 0, 0, 8'hFF, 4'b0101);
    vecs[14] = mk(0, 1, 0, 1, 8'h00, 0, 0, 8'hFF, 4'b0100);
    vecs[15] = mk(0, 0, 0, 1, 8'h00, 0, 1, 8'hFF, 4'b0000);
    vecs[16] = mk(1, 1, 1, 0, 8'h10, 0, 0, 8'h10, 4'b0000);
    vecs[17] = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'h10, 4'b0000);
    vecs[18] = mk(0, 1, 1, 0, 8'h00, 0, 0, 8'h11, 4'b0000);
    vecs[19] = mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h11, 4'b0000);
    vecs[20] = mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h10, 4'b0000);

    rst = 1'b1;
    drive(0, 0, 1, 0, 8'h00, 0, 0);
    step(); step();
    chk("reset_tcnt", TCNT, 8'h00);
    chk("reset_flags", flg(), 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) step();
    chk("idle_tcnt", TCNT, 8'h00);
    chk("idle_flags", flg(), 4'b0000);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].ck, vecs[i].sv, vecs[i].oc, vecs[i].uc);
      step();
      chk($sformatf("vec%0d_tcnt", i), TCNT, vecs[i].e_tcnt);
      chk($sformatf("vec%0d_flags", i), flg(), vecs[i].e_flg);
    end

    // Divide sweep: five up-ticks take 10/20/40/80 enabled cycles.
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 2'(k), 8'h00, 0, 0);
      step();
      drive(0, 1, 1, 2'(k), 8'h00, 0, 0);
      repeat ((10 << k) - 1) step();
      chk($sformatf("sweep%0d_pre", k), TCNT, 8'h04);
      step();
      chk($sformatf("sweep%0d_end", k), TCNT, 8'h05);
    end

    // Overflow clear coincides with the wrap edge: set wins.
    drive(1, 0, 1, 0, 8'hFF, 0, 0);
    step();
    drive(0, 1, 1, 0, 8'h00, 0, 0);
    step();
    chk("setclr_before", TCNT, 8'hFF);
    drive(0, 1, 1, 0, 8'h00, 1, 0);
    step();
    chk("setclr_tcnt", TCNT, 8'h00);
    chk("setclr_flags", flg(), 4'b1010);
    drive(0, 0, 1, 0, 8'h00, 0, 0);
    step();
    chk("setclr_after", flg(), 4'b1000);

    // Down from 0x01 at /16: 0x00 at edge 16, wrap to 0xFF at edge 32.
    drive(1, 0, 0, 3, 8'h01, 0, 0);
    step();
    drive(0, 1, 0, 3, 8'h00, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 15) chk("down16_pre", TCNT, 8'h01);
      if (i == 16) chk("down16_zero", {TCNT, flg()}, {8'h00, 4'b1000});
      if (i == 31) chk("down16_prewrap", {TCNT, flg()}, {8'h00, 4'b1000});
      if (i == 32) chk("down16_wrap", {TCNT, flg()}, {8'hFF, 4'b1101});
    end
    drive(0, 0, 0, 3, 8'h00, 0, 0);
    step();
    chk("udf_sticky", flg(), 4'b1100);
    drive(0, 0, 0, 3, 8'h00, 1, 0);
    step();
    chk("ovf_clr_only", flg(), 4'b0100);

    // Load held high overrides an enabled counter.
    drive(1, 1, 1, 0, 8'h80, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("loadhold%0d", i), {TCNT, ovf_pulse, udf_pulse}, {8'h80, 2'b00});
    end
    chk("loadhold_flags", flg(), 4'b0100);

    // Async reset between edges mid-count.
    drive(1, 0, 1, 0, 8'h36, 0, 0);
    step();
    drive(0, 1, 1, 0, 8'h00, 0, 0);
    step(); step();
    chk("prereset", {TCNT, flg()}, {8'h37, 4'b0100});
    #3 rst = 1'b1;
    #1 chk("async_reset", {TCNT, flg()}, {8'h00, 4'b0000});
    #2 rst = 1'b0;
    step();
    chk("postreset_e1", TCNT, 8'h00);
    step();
    chk("postreset_e2", {TCNT, flg()}, {8'h01, 4'b0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
